// File: rtl/axi_read_slave.sv
// rtl/axi_read_slave.sv - single-outstanding AXI read burst slave over a byte memory
module axi_read_slave #(
    parameter int BUS_WIDTH  = 32,
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_AW     = 7
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [ID_WIDTH-1:0]   ARID,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [3:0]            ARLEN,
    input  logic [1:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [ID_WIDTH-1:0]   RID,
    output logic [BUS_WIDTH-1:0]  RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  mem_cs,
    output logic [MEM_AW-1:0]     mem_raddr,
    input  logic [BUS_WIDTH-1:0]  mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MEMRD = 2'd1;
    localparam logic [1:0] CAPT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            len_q, len_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [3:0]            beat_q, beat_d;
    logic                  err_q, err_d;
    logic                  arready_q, arready_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [BUS_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic                  rvalid_q, rvalid_d;
    logic                  mem_cs_q, mem_cs_d;
    logic [MEM_AW-1:0]     mem_raddr_q, mem_raddr_d;

    logic                  ar_err;
    logic [ADDR_WIDTH-1:0] incr, blk, wmask, next_addr;
    int                    nbytes;

    // Burst legality check on the incoming request and next-beat address generation.
    always_comb begin
        ar_err = (ARBURST == 2'b11) || (ARSIZE == 2'b11) ||
                 ((ARBURST == 2'b10) && !((ARLEN == 4'd1) || (ARLEN == 4'd3) ||
                                          (ARLEN == 4'd7) || (ARLEN == 4'd15)));
        incr  = ADDR_WIDTH'(1) << size_q;
        blk   = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
        wmask = blk - ADDR_WIDTH'(1);
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~wmask) | ((addr_q + incr) & wmask);
            default: next_addr = addr_q + incr;
        endcase
    end

    // Burst FSM; all outputs are registered so reset forces them low, ARREADY included.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        err_d       = err_q;
        arready_d   = arready_q;
        rid_d       = rid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;
        rvalid_d    = rvalid_q;
        mem_cs_d    = 1'b0;
        mem_raddr_d = mem_raddr_q;
        nbytes      = 1 << size_q;
        case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    id_d      = ARID;
                    addr_d    = ARADDR;
                    len_d     = ARLEN;
                    size_d    = ARSIZE;
                    burst_d   = ARBURST;
                    beat_d    = 4'd0;
                    err_d     = ar_err;
                    arready_d = 1'b0;
                    if (ar_err) begin
                        // Error bursts never touch memory: respond straight away.
                        state_d  = RESP;
                        rid_d    = ARID;
                        rdata_d  = '0;
                        rresp_d  = 2'b10;
                        rlast_d  = (ARLEN == 4'd0);
                        rvalid_d = 1'b1;
                    end else begin
                        state_d     = MEMRD;
                        mem_cs_d    = 1'b1;
                        mem_raddr_d = ARADDR[MEM_AW-1:0];
                    end
                end
            end
            MEMRD: begin
                state_d = CAPT;
            end
            CAPT: begin
                state_d = RESP;
                for (int i = 0; i < BUS_WIDTH / 8; i++) begin
                    rdata_d[i*8 +: 8] = (i < nbytes) ? mem_rdata[i*8 +: 8] : 8'h00;
                end
                rid_d    = id_q;
                rresp_d  = 2'b00;
                rlast_d  = (beat_q == len_q);
                rvalid_d = 1'b1;
            end
            default: begin
                if (RREADY) begin
                    if (beat_q == len_q) begin
                        state_d   = IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 4'd1;
                        addr_d = next_addr;
                        if (err_q) begin
                            rlast_d = ((beat_q + 4'd1) == len_q);
                        end else begin
                            state_d     = MEMRD;
                            rvalid_d    = 1'b0;
                            rlast_d     = 1'b0;
                            mem_cs_d    = 1'b1;
                            mem_raddr_d = next_addr[MEM_AW-1:0];
                        end
                    end
                end
            end
        endcase
    end

    // State and output registers with synchronous active-high clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            arready_q   <= 1'b0;
            rid_q       <= '0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            rlast_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_raddr_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            arready_q   <= arready_d;
            rid_q       <= rid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            rlast_q     <= rlast_d;
            rvalid_q    <= rvalid_d;
            mem_cs_q    <= mem_cs_d;
            mem_raddr_q <= mem_raddr_d;
        end
    end

    assign ARREADY   = arready_q;
    assign RID       = rid_q;
    assign RDATA     = rdata_q;
    assign RRESP     = rresp_q;
    assign RLAST     = rlast_q;
    assign RVALID    = rvalid_q;
    assign mem_cs    = mem_cs_q;
    assign mem_raddr = mem_raddr_q;

endmodule

// File: tb/tb_axi_read_slave.sv
// tb/tb_axi_read_slave.sv - directed bench for axi_read_slave with a byte memory model
module tb_axi_read_slave;

    logic        clk = 1'b0;
    logic        clr;
    logic [0:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [1:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [0:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        mem_cs;
    logic [6:0]  mem_raddr;
    logic [31:0] mem_rdata = '0;

    int tests  = 0;
    int failed = 0;
    int cs_count = 0;
    logic [6:0] raddr_log[$];
    logic [7:0] mem[128];

    axi_read_slave dut (
        .clk(clk), .clr(clr),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .mem_cs(mem_cs), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i);
    end

    always @(posedge clk) begin
        if (mem_cs) begin
            mem_rdata <= {mem[7'(mem_raddr + 7'd3)], mem[7'(mem_raddr + 7'd2)],
                          mem[7'(mem_raddr + 7'd1)], mem[mem_raddr]};
        end
    end

    always @(negedge clk) begin
        if (mem_cs === 1'b1) begin
            cs_count <= cs_count + 1;
            raddr_log.push_back(mem_raddr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue_ar(input logic id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] size, input logic [1:0] burst);
        int n;
        n = 0;
        while (ARREADY !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("arready_wait", {31'd0, ARREADY}, 32'd1);
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
        ARVALID = 1'b1;
        @(posedge clk);
        #1 ARVALID = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_rv();
        int n;
        n = 0;
        while (RVALID !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rvalid_wait", {31'd0, RVALID}, 32'd1);
    endtask

    task automatic beat(input string tag, input logic [31:0] data, input logic last,
                        input logic [1:0] resp, input logic id);
        wait_rv();
        chk({tag, "_data"}, RDATA, data);
        chk({tag, "_last"}, {31'd0, RLAST}, {31'd0, last});
        chk({tag, "_resp"}, {30'd0, RRESP}, {30'd0, resp});
        chk({tag, "_id"}, {31'd0, RID}, {31'd0, id});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cs0;
        logic [31:0] held;
        clr = 1'b1; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0;
        ARSIZE = '0; ARBURST = '0; RREADY = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_arready", {31'd0, ARREADY}, 32'd0);
        chk("rst_rvalid", {31'd0, RVALID}, 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_memcs", {31'd0, mem_cs}, 32'd0);
        chk("rst_raddr", {25'd0, mem_raddr}, 32'd0);
        chk("rst_rlast_rresp", {29'd0, RLAST, RRESP}, 32'd0);
        clr = 1'b0;
        @(negedge clk);
        chk("post_rst_arready", {31'd0, ARREADY}, 32'd1);

        // INCR halfword burst, first-beat latency
        issue_ar(1'b0, 32'h00, 4'd3, 2'd1, 2'b01);
        chk("incr_lat1", {31'd0, RVALID}, 32'd0);
        @(negedge clk);
        chk("incr_lat2", {31'd0, RVALID}, 32'd0);
        @(negedge clk);
        chk("incr_lat3", {31'd0, RVALID}, 32'd1);
        beat("incr_b0", 32'h00000100, 1'b0, 2'b00, 1'b0);
        beat("incr_b1", 32'h00000302, 1'b0, 2'b00, 1'b0);
        beat("incr_b2", 32'h00000504, 1'b0, 2'b00, 1'b0);
        beat("incr_b3", 32'h00000706, 1'b1, 2'b00, 1'b0);
        chk("incr_cs_count", cs_count, 32'd4);

        // WRAP word burst starting at the top of a 16-byte block
        raddr_log.delete();
        issue_ar(1'b1, 32'h0C, 4'd3, 2'd2, 2'b10);
        beat("wrap_b0", 32'h0F0E0D0C, 1'b0, 2'b00, 1'b1);
        beat("wrap_b1", 32'h03020100, 1'b0, 2'b00, 1'b1);
        beat("wrap_b2", 32'h07060504, 1'b0, 2'b00, 1'b1);
        beat("wrap_b3", 32'h0B0A0908, 1'b1, 2'b00, 1'b1);
        chk("wrap_nlog", raddr_log.size(), 32'd4);
        if (raddr_log.size() == 4) begin
            chk("wrap_ra0", {25'd0, raddr_log[0]}, 32'h0C);
            chk("wrap_ra1", {25'd0, raddr_log[1]}, 32'h00);
            chk("wrap_ra2", {25'd0, raddr_log[2]}, 32'h04);
            chk("wrap_ra3", {25'd0, raddr_log[3]}, 32'h08);
        end

        // FIXED byte burst
        raddr_log.delete();
        issue_ar(1'b0, 32'h14, 4'd2, 2'd0, 2'b00);
        beat("fix_b0", 32'h00000014, 1'b0, 2'b00, 1'b0);
        beat("fix_b1", 32'h00000014, 1'b0, 2'b00, 1'b0);
        beat("fix_b2", 32'h00000014, 1'b1, 2'b00, 1'b0);
        chk("fix_nlog", raddr_log.size(), 32'd3);
        for (int i = 0; i < raddr_log.size(); i++) chk("fix_ra", {25'd0, raddr_log[i]}, 32'h14);

        // Reserved burst type: SLVERR, no memory access
        cs0 = cs_count;
        issue_ar(1'b1, 32'h08, 4'd1, 2'd2, 2'b11);
        beat("err_b0", 32'h0, 1'b0, 2'b10, 1'b1);
        beat("err_b1", 32'h0, 1'b1, 2'b10, 1'b1);
        chk("err_no_cs", cs_count, cs0);

        // WRAP with illegal length 2: three SLVERR beats
        issue_ar(1'b0, 32'h04, 4'd2, 2'd2, 2'b10);
        beat("wlen_b0", 32'h0, 1'b0, 2'b10, 1'b0);
        beat("wlen_b1", 32'h0, 1'b0, 2'b10, 1'b0);
        beat("wlen_b2", 32'h0, 1'b1, 2'b10, 1'b0);
        chk("wlen_no_cs", cs_count, cs0);

        // Address above the memory window aliases down
        issue_ar(1'b0, 32'h80, 4'd0, 2'd2, 2'b01);
        beat("alias_b0", 32'h03020100, 1'b1, 2'b00, 1'b0);

        // Back-pressure on beat 1 of a 2-beat INCR burst
        RREADY = 1'b0;
        issue_ar(1'b0, 32'h20, 4'd1, 2'd2, 2'b01);
        wait_rv();
        held = RDATA;
        chk("stall_data", RDATA, 32'h23222120);
        cs0 = cs_count;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rvalid", {31'd0, RVALID}, 32'd1);
            chk("stall_rdata", RDATA, held);
            chk("stall_arready", {31'd0, ARREADY}, 32'd0);
            @(negedge clk);
        end
        chk("stall_no_cs", cs_count, cs0);
        RREADY = 1'b1;
        beat("stall_b0", 32'h23222120, 1'b0, 2'b00, 1'b0);
        beat("stall_b1", 32'h27262524, 1'b1, 2'b00, 1'b0);

        // Clear pulse during beat 2 abandons the burst
        issue_ar(1'b0, 32'h00, 4'd3, 2'd2, 2'b01);
        beat("clr_b0", 32'h03020100, 1'b0, 2'b00, 1'b0);
        wait_rv();
        RREADY = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("clr_rvalid", {31'd0, RVALID}, 32'd0);
        chk("clr_arready", {31'd0, ARREADY}, 32'd0);
        chk("clr_rdata", RDATA, 32'd0);
        chk("clr_memcs_raddr", {24'd0, mem_cs, mem_raddr}, 32'd0);
        chk("clr_rid_last_resp", {28'd0, RID, RLAST, RRESP}, 32'd0);
        clr = 1'b0;
        RREADY = 1'b1;
        @(negedge clk);
        chk("clr_arready_after", {31'd0, ARREADY}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("clr_no_rvalid", {31'd0, RVALID}, 32'd0);
            @(negedge clk);
        end
        issue_ar(1'b1, 32'h30, 4'd0, 2'd2, 2'b01);
        beat("clr_new", 32'h33323130, 1'b1, 2'b00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/axi_read_slave.md
AXI_READ_SLAVE -- requirements
Module: axi_read_slave

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32: R data width in bits.
REQ-002 SHALL have parameter ID_WIDTH, default 1: width of ARID/RID.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: width of ARADDR.
REQ-004 SHALL have parameter MEM_AW, default 7: width of the memory read address.
REQ-005 SHALL have ports `clk` (in, 1), the single clock, with all logic on its rising edge, and `clr` (in, 1), reset, synchronous and active-high.
REQ-006 SHALL have AR channel inputs:
- ARID (in, ID_WIDTH);
- ARADDR (in, ADDR_WIDTH);
- ARLEN (in, 4): beats minus 1;
- ARSIZE (in, 2): bytes per beat = 1<<ARSIZE;
- ARBURST (in, 2): 00 FIXED, 01 INCR, 10 WRAP, 11 reserved;
- ARVALID (in, 1).
REQ-007 SHALL have ARREADY (out, 1): AR handshake ready.
REQ-008 SHALL have R channel outputs RID (ID_WIDTH), RDATA (BUS_WIDTH), RRESP (2), RLAST (1) and RVALID (1), plus input RREADY (1).
REQ-009 SHALL have memory ports:
- mem_cs (out, 1): read strobe;
- mem_raddr (out, MEM_AW): byte address;
- mem_rdata (in, BUS_WIDTH): little-endian bytes mem[raddr..raddr+3], valid the cycle after mem_cs.

Function
REQ-010 SHALL implement a 4-state FSM: IDLE, MEMRD, CAPT, RESP.
REQ-011 IDLE SHALL behave as follows:
- ARREADY=1.
- On ARVALID=1, latch ARID, ARADDR, ARLEN, ARSIZE and ARBURST, clear the beat counter, and go to MEMRD.
REQ-012 MEMRD SHALL assert mem_cs=1 for exactly one cycle with mem_raddr=addr[MEM_AW-1:0], then go to CAPT.
REQ-013 CAPT SHALL register RDATA from mem_rdata and go to RESP.
- Bytes at and above 1<<size SHALL be zeroed: size 0 keeps [7:0], size 1 keeps [15:0], size 2 keeps all.
REQ-014 RESP SHALL drive RVALID=1 with RID, RDATA, RRESP and RLAST held stable until RREADY=1.
REQ-015 On the RESP handshake (RVALID&&RREADY):
- if beat==len, go to IDLE;
- otherwise increment beat, update addr per REQ-016, and go to MEMRD.
REQ-016 The next address SHALL be computed by burst type:
- FIXED: unchanged.
- INCR: addr + (1<<size), modulo 2^ADDR_WIDTH.
- WRAP: addr + (1<<size) within the aligned block of (len+1)<<size bytes, wrapping to the block base on crossing its upper boundary.
REQ-017 RLAST SHALL be 1 only on the beat where beat==len.
REQ-018 RRESP SHALL be 2'b00 (OKAY) for a legal burst.
REQ-019 A burst SHALL be an error burst if any of these holds:
- ARBURST=11;
- ARSIZE=11;
- WRAP with len not in {1,3,7,15}.
REQ-020 An error burst SHALL still produce len+1 beats with RRESP=2'b10 (SLVERR) and RDATA=0.
- For an error burst, mem_cs SHALL never assert and MEMRD/CAPT SHALL be skipped, with IDLE→RESP and RESP→RESP between beats.
REQ-021 ARREADY SHALL be 0 in every state other than IDLE, so only one burst is outstanding at a time.
REQ-022 A legal burst SHALL take a minimum of 3 cycles per beat (MEMRD, CAPT, RESP with RREADY=1), and first RVALID SHALL rise 3 cycles after the AR handshake edge.
REQ-023 Back-pressure (RREADY=0) SHALL stall in RESP indefinitely with no further mem_cs.
REQ-024 Higher ARADDR bits SHALL be ignored for mem_raddr, so address 0x80 reads mem[0x00].

Reset
REQ-025 While clr=1 at a clock edge, the FSM SHALL go to IDLE.
- ARREADY=0, RVALID=0, RLAST=0, RDATA=0, RID=0, RRESP=0, mem_cs=0, mem_raddr=0.
- All latched burst fields and the beat counter SHALL be cleared.
REQ-026 A burst in progress when clr asserts SHALL be abandoned with no further R beats.
- ARREADY=1 SHALL appear on the first edge after clr deasserts.

Verification (memory preloaded with mem[i]=i)
REQ-027 INCR burst, ARADDR=0x00, ARLEN=3, ARSIZE=1, RREADY=1 → RDATA 0x00000100, 0x00000302, 0x00000504, 0x00000706, RLAST on the 4th beat, RRESP=00, first RVALID 3 cycles after AR handshake.
REQ-028 WRAP burst, ARADDR=0x0C, ARLEN=3, ARSIZE=2 → mem_raddr 0x0C, 0x00, 0x04, 0x08, with RDATA 0x0F0E0D0C, 0x03020100, 0x07060504, 0x0B0A0908.
REQ-029 FIXED burst, ARADDR=0x14, ARLEN=2, ARSIZE=0 → three beats of RDATA=0x00000014, mem_raddr=0x14 each beat.
REQ-030 ARBURST=11, ARLEN=1 → two beats RRESP=10, RDATA=0, RLAST on the 2nd beat, mem_cs never 1.
REQ-031 RREADY held 0 for 5 cycles on beat 1 of a 2-beat INCR burst → RVALID and RDATA stable for the stall, ARREADY=0, no mem_cs; the burst completes normally after RREADY=1.
REQ-032 clr pulsed for one cycle during beat 2 of ARLEN=3 → all outputs 0 that cycle, no further RVALID, ARREADY=1 the next cycle, and a new burst with ARID=1 returns RID=1.
